// File: rtl/hamming_rr_sched_if.sv
// Request/result bundle for hamming_rr_sched. The master side (operand
// front-ends and result collector) drives requests and consumes results.
// Optional macro THRESH_MATCH_EN adds thresh/res_match.
interface hamming_rr_sched_if #(
   parameter int unsigned N  = 1600,
   parameter int unsigned CW = 11
);
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [N-1:0]  req_x0;
   logic [N-1:0]  req_y0;
   logic [N-1:0]  req_x1;
   logic [N-1:0]  req_y1;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_dist;
   logic          res_id;
   logic          busy;
`ifdef THRESH_MATCH_EN
   logic [CW-1:0] thresh;
   logic          res_match;

   modport master (
      output req_valid, req_x0, req_y0, req_x1, req_y1, res_ready, thresh,
      input  req_ready, res_valid, res_dist, res_id, busy, res_match
   );
   modport slave (
      input  req_valid, req_x0, req_y0, req_x1, req_y1, res_ready, thresh,
      output req_ready, res_valid, res_dist, res_id, busy, res_match
   );
`else
   modport master (
      output req_valid, req_x0, req_y0, req_x1, req_y1, res_ready,
      input  req_ready, res_valid, res_dist, res_id, busy
   );
   modport slave (
      input  req_valid, req_x0, req_y0, req_x1, req_y1, res_ready,
      output req_ready, res_valid, res_dist, res_id, busy
   );
`endif
endinterface

// File: rtl/hamming_rr_sched.sv
// Round-robin scheduler sharing one bit-serial Hamming-distance accumulator
// between two requesters. A granted x/y pair is shifted out LSB first, one
// bit pair per cycle for N cycles, and the distance is returned tagged with
// the requester id on a valid/ready channel.
// Optional macro THRESH_MATCH_EN: adds res_match = (distance <= thresh),
// with thresh sampled at the request handshake.
module hamming_rr_sched #(
   parameter int unsigned N  = 1600,
   parameter int unsigned CW = 11
) (
   input logic               clk,
   input logic               rst,
   hamming_rr_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  xs_q;
   logic [N-1:0]  ys_q;
   logic [CW-1:0] acc_q;
   logic [CW-1:0] acc_d;
   logic [CW-1:0] cnt_q;
   logic          gid_q;
   logic          rr_last_q;
   logic          res_valid_q;
   logic          busy_q;
   logic [1:0]    grant_c;
   logic [N-1:0]  sel_x_c;
   logic [N-1:0]  sel_y_c;
`ifdef THRESH_MATCH_EN
   logic [CW-1:0] thr_q;
   logic          res_match_q;
`endif

   // Grant only while idle; a tie goes to the requester not served last
   always_comb begin
      grant_c = 2'b00;
      if (!rst && state_q == IDLE) begin
         case (bus.req_valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = rr_last_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
         endcase
      end
   end

   // Operand mux for the granted requester and next accumulator value
   always_comb begin
      sel_x_c = grant_c[1] ? bus.req_x1 : bus.req_x0;
      sel_y_c = grant_c[1] ? bus.req_y1 : bus.req_y0;
      acc_d   = acc_q + CW'(xs_q[0] ^ ys_q[0]);
   end

   // Scheduler FSM, shift registers, bit counter and accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         xs_q        <= '0;
         ys_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         gid_q       <= 1'b0;
         rr_last_q   <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef THRESH_MATCH_EN
         thr_q       <= '0;
         res_match_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_c != 2'b00) begin
                  xs_q      <= sel_x_c;
                  ys_q      <= sel_y_c;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  gid_q     <= grant_c[1];
                  rr_last_q <= grant_c[1];
                  busy_q    <= 1'b1;
`ifdef THRESH_MATCH_EN
                  thr_q     <= bus.thresh;
`endif
                  state_q   <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               xs_q  <= xs_q >> 1;
               ys_q  <= ys_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  res_valid_q <= 1'b1;
`ifdef THRESH_MATCH_EN
                  res_match_q <= (acc_d <= thr_q);
`endif
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = grant_c;
   assign bus.res_valid = res_valid_q;
   assign bus.res_dist  = acc_q;
   assign bus.res_id    = gid_q;
   assign bus.busy      = busy_q;
`ifdef THRESH_MATCH_EN
   assign bus.res_match = res_match_q;
`endif

endmodule

// File: tb/tb_hamming_rr_sched.sv
// Bench for hamming_rr_sched: a small N=8 instance checked every cycle
// against a job-level model, plus a default N=1600 instance for the
// full-length count. Optional macro THRESH_MATCH_EN enables res_match checks.
`timescale 1ns/1ps
module tb_hamming_rr_sched;

   localparam int unsigned N   = 8;
   localparam int unsigned CW  = 4;
   localparam int unsigned BN  = 1600;
   localparam int unsigned BCW = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hamming_rr_sched_if #(.N(N),  .CW(CW))  bus  ();
   hamming_rr_sched_if #(.N(BN), .CW(BCW)) bbus ();

   hamming_rr_sched #(.N(N),  .CW(CW))  dut     (.clk(clk), .rst(rst), .bus(bus));
   hamming_rr_sched #(.N(BN), .CW(BCW)) dut_big (.clk(clk), .rst(rst), .bus(bbus));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- job-level reference model ----------------
   // A job is: grant -> N cycles of counting -> result presented until taken.
   logic       m_busy;
   int         m_rem;     // cycles until the result appears
   int         m_dist;
   logic       m_id;
   logic       m_last;    // requester served last
   int         m_thr;
   logic [1:0] m_g;
   logic [N-1:0] m_x, m_y;

   int   log_dist[$];
   logic log_id[$];
   logic log_match[$];

   function automatic logic [1:0] exp_grant(input logic [1:0] v);
      if (rst || m_busy) return 2'b00;
      if (v == 2'b11)    return m_last ? 2'b01 : 2'b10;
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0; m_rem = 0; m_dist = 0; m_id = 1'b0; m_last = 1'b1; m_thr = 0;
      end else begin
         m_g = exp_grant(bus.req_valid);
         if (!m_busy) begin
            if (m_g != 2'b00) begin
               m_id   = m_g[1];
               m_x    = m_id ? bus.req_x1 : bus.req_x0;
               m_y    = m_id ? bus.req_y1 : bus.req_y0;
               m_dist = $countones(m_x ^ m_y);
               m_last = m_id;
               m_busy = 1'b1;
               m_rem  = N;
`ifdef THRESH_MATCH_EN
               m_thr  = int'(bus.thresh);
`endif
            end
         end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
         end else if (bus.res_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   // Compare DUT against model on the falling edge
   always @(negedge clk) begin
      chk("req_ready", bus.req_ready, exp_grant(bus.req_valid));
      chk("busy", bus.busy, m_busy);
      chk("res_valid", bus.res_valid, (m_busy && m_rem == 0));
      if (rst) begin
         chk("rst_res_dist", bus.res_dist, 0);
         chk("rst_res_id", bus.res_id, 0);
      end
      if (m_busy && m_rem == 0) begin
         chk("res_dist", bus.res_dist, m_dist);
         chk("res_id", bus.res_id, m_id);
`ifdef THRESH_MATCH_EN
         chk("res_match", bus.res_match, (m_dist <= m_thr));
`endif
         if (bus.res_ready) begin
            log_dist.push_back(int'(bus.res_dist));
            log_id.push_back(bus.res_id);
`ifdef THRESH_MATCH_EN
            log_match.push_back(bus.res_match);
`else
            log_match.push_back(1'b0);
`endif
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_result(input string name, output int lat);
      lat = 0;
      while (!bus.res_valid && lat < 200) begin
         tick();
         lat++;
      end
      if (!bus.res_valid) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got no res_valid expected res_valid within 200 cycles", name);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (bus.busy && k < 200) begin
         tick();
         k++;
      end
      if (bus.busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
      end
   endtask

   // Single job on requester 0; returns latency
   task automatic run_job0(input logic [N-1:0] x, input logic [N-1:0] y, input string name, output int lat);
      bus.req_x0    = x;
      bus.req_y0    = y;
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      wait_result(name, lat);
   endtask

   int lat;
   int base;
   logic [CW-1:0] held_dist;

   initial begin
      bus.req_valid = 2'b00;
      bus.req_x0 = '0; bus.req_y0 = '0; bus.req_x1 = '0; bus.req_y1 = '0;
      bus.res_ready = 1'b1;
      bbus.req_valid = 2'b00;
      bbus.req_x0 = '0; bbus.req_y0 = '0; bbus.req_x1 = '0; bbus.req_y1 = '0;
      bbus.res_ready = 1'b1;
`ifdef THRESH_MATCH_EN
      bus.thresh  = '0;
      bbus.thresh = '0;
`endif

      // Reset state
      repeat (3) tick();
      chk("reset_busy", bus.busy, 0);
      chk("reset_res_valid", bus.res_valid, 0);
      chk("reset_req_ready", bus.req_ready, 0);
      rst = 1'b0;
      tick();

      // Single job: F0 vs 0F differ in all 8 bits
      bus.req_x0 = 8'hF0; bus.req_y0 = 8'h0F; bus.req_valid = 2'b01;
      #1;
      chk("single_grant", bus.req_ready, 2'b01);
      tick();
      bus.req_valid = 2'b00;
      chk("single_grant_drop", bus.req_ready, 2'b00);
      wait_result("single", lat);
      chk("single_latency", 64'(lat), 64'(N));
      chk("single_dist", bus.res_dist, 8);
      chk("single_id", bus.res_id, 0);
      tick();
      wait_idle();

      // Tie / round-robin from reset: 0,1,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      base = log_id.size();
      bus.req_x0 = 8'hAA; bus.req_y0 = 8'hAA;
      bus.req_x1 = 8'hFF; bus.req_y1 = 8'h00;
      bus.req_valid = 2'b11;
      repeat (3 * (N + 2) + 2) tick();
      bus.req_valid = 2'b00;
      wait_idle();
      tick();
      if (log_id.size() < base + 3) begin
         checks++;
         failures++;
         $display("FAIL tie_count: got %0d results expected at least 3", log_id.size() - base);
      end else begin
         chk("tie0_id", log_id[base], 0);     chk("tie0_dist", 64'(log_dist[base]), 0);
         chk("tie1_id", log_id[base+1], 1);   chk("tie1_dist", 64'(log_dist[base+1]), 8);
         chk("tie2_id", log_id[base+2], 0);   chk("tie2_dist", 64'(log_dist[base+2]), 0);
      end

      // Backpressure: requester 1 job held 5 cycles; requester 0 waits
      bus.res_ready = 1'b0;
      bus.req_x1 = 8'h3C; bus.req_y1 = 8'h00;
      bus.req_x0 = 8'h01; bus.req_y0 = 8'h00;
      bus.req_valid = 2'b10;
      tick();
      bus.req_valid = 2'b01;
      wait_result("bp", lat);
      held_dist = bus.res_dist;
      chk("bp_dist", bus.res_dist, 4);
      chk("bp_id", bus.res_id, 1);
      repeat (5) begin
         tick();
         chk("bp_hold_valid", bus.res_valid, 1);
         chk("bp_hold_dist", bus.res_dist, held_dist);
         chk("bp_hold_ready", bus.req_ready, 2'b00);
      end
      bus.res_ready = 1'b1;
      #1;
      chk("bp_no_same_cycle", bus.req_ready, 2'b00);
      tick();
      chk("bp_resume", bus.req_ready, 2'b01);
      tick();
      bus.req_valid = 2'b00;
      wait_result("bp2", lat);
      chk("bp2_dist", bus.res_dist, 1);
      tick();
      wait_idle();

      // Reset in the 4th RUN cycle, then a fresh job
      bus.req_x0 = 8'hFF; bus.req_y0 = 8'h00; bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_res_valid", bus.res_valid, 0);
      chk("midrst_res_dist", bus.res_dist, 0);
      chk("midrst_req_ready", bus.req_ready, 0);
      tick();
      rst = 1'b0;
      base = log_id.size();
      run_job0(8'h01, 8'h00, "midrst_job", lat);
      chk("midrst_job_dist", bus.res_dist, 1);
      chk("midrst_job_id", bus.res_id, 0);
      tick();
      wait_idle();
      chk("midrst_no_stale", 64'(log_id.size()), 64'(base + 1));

`ifdef THRESH_MATCH_EN
      // Threshold compare: distance 3 against thresh 3 and 2
      bus.thresh = 4'd3;
      run_job0(8'h07, 8'h00, "thr3", lat);
      chk("thr3_match", bus.res_match, 1);
      tick();
      wait_idle();
      bus.thresh = 4'd2;
      run_job0(8'h07, 8'h00, "thr2", lat);
      chk("thr2_match", bus.res_match, 0);
      tick();
      wait_idle();
`endif

      // Random traffic; operands change every cycle including during RUN
      for (int i = 0; i < 600; i++) begin
         bus.req_valid = 2'($urandom_range(0, 3));
         bus.req_x0 = N'($urandom); bus.req_y0 = N'($urandom);
         bus.req_x1 = N'($urandom); bus.req_y1 = N'($urandom);
         bus.res_ready = ($urandom_range(0, 3) != 0);
`ifdef THRESH_MATCH_EN
         bus.thresh = CW'($urandom);
`endif
         tick();
      end
      bus.req_valid = 2'b00;
      bus.res_ready = 1'b1;
      wait_idle();
      tick();

      // Full-length job on the default-size instance
      bbus.req_x0 = '1; bbus.req_y0 = '0; bbus.req_valid = 2'b01;
      #1;
      chk("big_grant", bbus.req_ready, 2'b01);
      tick();
      bbus.req_valid = 2'b00;
      lat = 0;
      while (!bbus.res_valid && lat < 2000) begin
         tick();
         lat++;
      end
      chk("big_valid", bbus.res_valid, 1);
      chk("big_latency", 64'(lat), 64'(BN));
      chk("big_dist", bbus.res_dist, 11'h640);
      chk("big_id", bbus.res_id, 0);
      tick();
      chk("big_handoff", bbus.res_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
